// File: rtl/seq_pkg.sv
// Shared definitions for the serial burst generator/detector pair: FSM states
// and the default framing constants both ends must agree on.
package seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      MATCH = 1'b1
   } state_e;

   localparam int                         SEQ_QUIET_LEN = 5;
   localparam int                         SEQ_PAT_LEN   = 4;
   localparam logic [SEQ_PAT_LEN-1:0]     SEQ_PATTERN   = 4'b1010;

endpackage : seq_pkg

// File: rtl/seq_burst_det.sv
// Serial burst receiver: hunts for a quiet run of zeros followed by the marker
// pattern, pulses detect/err per burst and keeps a saturating detection count.
module seq_burst_det
   import seq_pkg::*;
#(
   parameter int                 QUIET_LEN = SEQ_QUIET_LEN,
   parameter int                 PAT_LEN   = SEQ_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN   = SEQ_PATTERN,
   parameter int                 CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             clr,
   output logic             detect,
   output logic             err,
   output logic             busy,
   output logic [CNT_W-1:0] det_count
);

   localparam int                ZRUN_W    = $clog2(QUIET_LEN + 1);
   localparam int                IDX_W     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
   localparam logic [ZRUN_W-1:0] ZRUN_FULL = ZRUN_W'(QUIET_LEN);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAT_LEN - 1);

   state_e             state_q, state_d;
   logic [ZRUN_W-1:0]  zrun_q, zrun_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               detect_q, detect_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [IDX_W-1:0]   bit_sel;
   logic               exp_bit;
   logic [ZRUN_W-1:0]  zrun_exit;

   // The marker is sent MSB first, so idx counts down from the top bit.
   assign bit_sel   = IDX_LAST - idx_q;
   assign exp_bit   = PATTERN[bit_sel];
   // A 0 that ends a marker attempt is already the first quiet zero.
   assign zrun_exit = din ? '0 : ZRUN_W'(1);

   // NOTE: every signal assigned below gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      zrun_d   = zrun_q;
      idx_d    = idx_q;
      detect_d = 1'b0;
      err_d    = 1'b0;
      cnt_d    = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (din) begin
               zrun_d = '0;
               if (zrun_q == ZRUN_FULL) begin
                  state_d = MATCH;
                  idx_d   = IDX_W'(1);
               end
            end else if (zrun_q != ZRUN_FULL) begin
               zrun_d = zrun_q + ZRUN_W'(1);
            end
         end

         MATCH: begin
            if (din != exp_bit) begin
               err_d   = 1'b1;
               state_d = IDLE;
               idx_d   = '0;
               zrun_d  = zrun_exit;
            end else if (idx_q == IDX_LAST) begin
               detect_d = 1'b1;
               state_d  = IDLE;
               idx_d    = '0;
               zrun_d   = zrun_exit;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
            zrun_d  = '0;
         end
      endcase

      // Clear takes priority over a detection landing on the same edge.
      if (clr) begin
         cnt_d = '0;
      end

      busy_d = (state_d == MATCH);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         zrun_q   <= '0;
         idx_q    <= '0;
         detect_q <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         zrun_q   <= zrun_d;
         idx_q    <= idx_d;
         detect_q <= detect_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign detect    = detect_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign det_count = cnt_q;

endmodule : seq_burst_det

// File: tb/tb_seq_burst_det.sv
// Self-checking bench for seq_burst_det: a history-based reference model scored
// every cycle, plus literal expectations at the key points of each scenario.
module tb_seq_burst_det;

   localparam int QUIET   = 5;
   localparam int PLEN    = 4;
   localparam int CNT_MAX = 255;

   logic       clk;
   logic       rst;
   logic       din;
   logic       clr;
   logic       detect;
   logic       err;
   logic       busy;
   logic [7:0] det_count;

   seq_burst_det dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .clr       (clr),
      .detect    (detect),
      .err       (err),
      .busy      (busy),
      .det_count (det_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: keeps the full sample history and decides each sample by
   // looking back over it, rather than by tracking a run counter.
   bit hist[$];
   bit pat_bits[PLEN] = '{1'b1, 1'b0, 1'b1, 1'b0};
   int free_from;
   int start;
   bit active;
   int exp_cnt;
   bit exp_det, exp_err, exp_busy;
   bit cmp_en = 1'b0;

   function automatic int quiet_before(input int t);
      int n = 0;
      for (int i = t - 1; i >= free_from && hist[i] == 1'b0; i--) n++;
      return n;
   endfunction

   task automatic model_reset();
      active    = 1'b0;
      free_from = hist.size();
      exp_cnt   = 0;
      exp_det   = 1'b0;
      exp_err   = 1'b0;
      exp_busy  = 1'b0;
   endtask

   task automatic model_step(input bit d, input bit c);
      int t;
      int k;
      t = hist.size();
      hist.push_back(d);
      exp_det = 1'b0;
      exp_err = 1'b0;
      if (!active) begin
         if (d && quiet_before(t) >= QUIET) begin
            active    = 1'b1;
            start     = t;
            free_from = t + 1;
         end
      end else begin
         k = t - start;
         if (d != pat_bits[k]) begin
            exp_err   = 1'b1;
            active    = 1'b0;
            free_from = d ? t + 1 : t;
         end else if (k == PLEN - 1) begin
            exp_det   = 1'b1;
            active    = 1'b0;
            free_from = d ? t + 1 : t;
            if (exp_cnt < CNT_MAX) exp_cnt++;
         end
      end
      if (c) exp_cnt = 0;
      exp_busy = active;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("detect", int'(detect), int'(exp_det));
         check("err", int'(err), int'(exp_err));
         check("busy", int'(busy), int'(exp_busy));
         check("det_count", int'(det_count), exp_cnt);
      end
   end

   // One sample: drive on the falling edge, advance the model on the rising edge.
   task automatic step(input bit d, input bit c = 1'b0);
      @(negedge clk);
      din = d;
      clr = c;
      @(posedge clk);
      model_step(d, c);
   endtask

   task automatic zeros(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic marker();
      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0);
   endtask

   int busy_cycles;
   int err_seen;

   initial begin
      rst = 1'b0;
      din = 1'b0;
      clr = 1'b0;
      #12;
      check("reset_detect", int'(detect), 0);
      check("reset_err", int'(err), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_count", int'(det_count), 0);
      rst = 1'b1;
      model_reset();
      cmp_en = 1'b1;

      // Basic burst: 6 zeros then the marker.
      zeros(6);
      busy_cycles = 0;
      err_seen    = 0;
      step(1'b1); #1 busy_cycles += int'(busy); err_seen += int'(err);
      step(1'b0); #1 busy_cycles += int'(busy); err_seen += int'(err);
      step(1'b1); #1 busy_cycles += int'(busy); err_seen += int'(err);
      check("t1_no_detect_early", int'(detect), 0);
      step(1'b0); #1 err_seen += int'(err);
      check("t1_detect", int'(detect), 1);
      check("t1_count", int'(det_count), 1);
      check("t1_busy_after", int'(busy), 0);
      check("t1_busy_cycles", busy_cycles, 3);
      check("t1_err_seen", err_seen, 0);
      step(1'b0); #1;
      check("t1_detect_one_cycle", int'(detect), 0);

      // Too short a quiet run: no detection.
      step(1'b1);
      zeros(3);
      marker(); #1;
      check("t2_no_detect", int'(detect), 0);
      check("t2_count", int'(det_count), 1);

      // Broken marker: 1,1 after a full quiet run.
      zeros(5);
      step(1'b1);
      step(1'b1); #1;
      check("t3_err", int'(err), 1);
      check("t3_busy", int'(busy), 0);
      step(1'b0); #1;
      check("t3_err_one_cycle", int'(err), 0);
      zeros(3);
      step(1'b1); #1;
      check("t3_zrun_restarted", int'(busy), 0);

      // Back-to-back bursts sharing the trailing zero; clr on the first quiet 0.
      step(1'b0, 1'b1); #1;
      check("t4_clr", int'(det_count), 0);
      zeros(4);
      marker(); #1;
      check("t4_first", int'(detect), 1);
      zeros(4);
      marker(); #1;
      check("t4_second", int'(detect), 1);
      check("t4_count", int'(det_count), 2);

      // Reset mid-marker after 1,0.
      zeros(4);
      step(1'b1);
      step(1'b0);
      #2 rst = 1'b0;
      #1;
      check("t5_busy_rst", int'(busy), 0);
      check("t5_count_rst", int'(det_count), 0);
      check("t5_detect_rst", int'(detect), 0);
      model_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      step(1'b1); #1;
      check("t5_no_start", int'(busy), 0);
      step(1'b0); #1;
      check("t5_no_detect", int'(detect), 0);
      check("t5_no_err", int'(err), 0);

      // Saturation: 255 bursts, then one more.
      for (int b = 0; b < CNT_MAX; b++) begin
         zeros(5);
         marker();
      end
      #1 check("t6_count_full", int'(det_count), 255);
      zeros(4);
      marker(); #1;
      check("t6_sat_detect", int'(detect), 1);
      check("t6_sat_count", int'(det_count), 255);

      // clr together with a detection: clr wins.
      zeros(4);
      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0, 1'b1); #1;
      check("t6_clr_detect", int'(detect), 1);
      check("t6_clr_count", int'(det_count), 0);
      zeros(2);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_seq_burst_det

// File: doc/seq_burst_det.md
Name: seq_burst_det

Overview:
- Receiver for the serial burst produced by our trigger-driven sequence generator: a quiet run of zeros, then the marker pattern 1,0,1,0.
- Samples a single-bit serial line on every rising clock edge and hunts for the framed pattern.
- Flags each complete burst with a one-cycle detect pulse, flags aborted bursts with an error pulse, and keeps a saturating detection count.
- Sits on the consumer side of the serial link, in the same clock domain as the generator.

Parameters:
- QUIET_LEN, 5, minimum number of consecutive 0 samples needed before a burst may start.
- PAT_LEN, 4, marker length in bits.
- PATTERN, 4'b1010, marker bits sent MSB first; the MSB must be 1.
- CNT_W, 8, width of the detection counter.

Ports:
- clk  in  1  system clock; all sampling on posedge.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  serial line (generator output y).
- clr  in  1  synchronous clear of det_count.
- detect  out  1  one-cycle pulse when a full framed marker has been received.
- err  out  1  one-cycle pulse when a started marker is broken.
- busy  out  1  high while a marker match is in progress.
- det_count  out  CNT_W  number of detections; saturates at all-ones.

Behaviour:
- Reset: rst low asynchronously forces the following, regardless of clk.
  - state=IDLE, zrun=0, idx=0.
  - detect=0, err=0, busy=0, det_count=0.
  - Reset mid-burst aborts silently: no detect and no err.
- zrun: counts consecutive 0 samples.
  - Saturates at QUIET_LEN.
  - Cleared by any 1 sample, except where a transition rule below sets it explicitly.
- States: IDLE and MATCH. All outputs are registered.
- IDLE:
  - din=1 and zrun==QUIET_LEN: go to MATCH, idx=1 (MSB matched), zrun=0.
  - din=1 and zrun<QUIET_LEN: stay in IDLE, zrun=0, no err.
  - din=0: zrun increments (saturating).
- MATCH:
  - The expected bit is PATTERN[PAT_LEN-1-idx].
  - din equals expected and idx<PAT_LEN-1: idx increments.
  - din equals expected and idx==PAT_LEN-1: detect=1 for the following cycle; det_count increments (saturating); return to IDLE; zrun=1 if the last bit is 0, otherwise 0.
  - din differs from expected: err=1 for the following cycle; return to IDLE; zrun=1 if din=0, otherwise 0.
- Latency: detect and err are high during the clock period that starts at the posedge sampling the final or offending bit.
- busy equals (state==MATCH), registered.
- No overlap:
  - A new burst always needs a fresh quiet run of QUIET_LEN zeros.
  - The trailing 0 of a marker counts as the first quiet zero.
- clr:
  - det_count=0 on the next posedge.
  - If clr and a detection happen in the same cycle, clr wins: count=0.
- det_count at all-ones stays at all-ones; detect still pulses.
- X on din is not handled; the bench must drive din to 0 or 1 after reset.

Decomposition:
- Shared package seq_pkg holds:
  - The state enum (IDLE, MATCH).
  - Default constants SEQ_QUIET_LEN=5, SEQ_PAT_LEN=4, SEQ_PATTERN=4'b1010.
  - The generator reuses the same constants.
- Single flat module. The zero-run counter is small and stays inline; no sub-module.

Test Plan:
- Reset, then din=0 for 6 cycles, then 1,0,1,0 -> detect high exactly 1 cycle, on the edge sampling the 4th bit; det_count=1; busy high for 3 cycles; err never high.
- Only 3 zeros, then 1,0,1,0 -> no detect; first 1 ignored; zrun restarts.
- 5 zeros, then 1,1 -> err pulses 1 cycle on the 2nd sample; zrun=0.
- Two bursts separated by 4 zeros after the first marker (1 trailing + 4 = 5 quiet) -> second burst detected; det_count=2.
- rst pulled low mid-marker (after 1,0) -> all outputs 0 immediately; no detect or err after release.
- Preload det_count to 255 via repeated bursts, one more burst -> stays 255 and detect still pulses; clr asserted together with a detection -> det_count=0.
